// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads,
// buffers returned words in a small FIFO and hands them downstream with a
// valid/ready handshake. Fetching stops on the halt sentinel opcode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [5:0]        HALT_OPC = 6'b111111;
  localparam logic [31:0]       PC_INC   = 32'(PC_STEP);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH      = 2'd1,
    S_WAIT_SPACE = 2'd2,
    S_HALT       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               outstanding_q, outstanding_d;
  logic               imem_req_q, imem_req_d;
  logic [31:0]        imem_addr_q, imem_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        instr_out_q, instr_out_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic               instr_valid_q, instr_valid_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];

  logic               rsp_take;
  logic               is_sentinel;
  logic               push;
  logic               pop;
  logic               req_pending;
  logic               flush;
  logic               issue;

  // Response classification and handshake decode
  assign rsp_take    = imem_rvalid && outstanding_q;
  assign is_sentinel = rsp_take && (imem_rdata[31:26] == HALT_OPC);
  assign push        = rsp_take && !is_sentinel && !flush;
  assign pop         = (count_q != '0) && instr_ready;
  // A request whose data arrives this cycle no longer blocks the next issue
  assign req_pending = outstanding_q && !imem_rvalid;

  // Next-state logic for control FSM, PC, request port and FIFO bookkeeping
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    imem_req_d    = 1'b0;
    imem_addr_d   = imem_addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    instr_out_d   = instr_out_q;
    pc_out_d      = pc_out_q;
    flush         = 1'b0;
    issue         = 1'b0;

    if (rsp_take) begin
      outstanding_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (is_sentinel) begin
          state_d = S_HALT;
        end else if (!req_pending) begin
          // The in-flight word still counts against buffer space
          if ((count_q + CNT_W'(outstanding_q)) < DEPTH_C) begin
            issue = 1'b1;
          end else begin
            state_d = S_WAIT_SPACE;
          end
        end
      end
      S_WAIT_SPACE: begin
        if (pop) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          flush   = 1'b1;
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      imem_req_d    = 1'b1;
      imem_addr_d   = pc_q;
      pc_d          = pc_q + PC_INC;
      outstanding_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Head register: the incoming word if it lands in an otherwise empty
      // buffer, else the entry at the new read pointer; hold when empty
      if (count_d != '0) begin
        if (count_q == CNT_W'(pop)) begin
          instr_out_d = imem_rdata;
          pc_out_d    = imem_addr_q;
        end else begin
          instr_out_d = instr_mem_q[rd_ptr_d];
          pc_out_d    = pc_mem_q[rd_ptr_d];
        end
      end
    end

    instr_valid_d = (count_d != '0);
    busy_d        = (state_d == S_FETCH) || (state_d == S_WAIT_SPACE);
    halted_d      = (state_d == S_HALT);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  // Buffer storage; contents are only meaningful under count_q
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= imem_addr_q;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_out   = instr_out_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4),
    .PC_STEP   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .halted     (halted)
  );

  localparam logic [31:0] SENT = 32'hFC00_0000;
  localparam logic [31:0] NO_SENT = 32'hFFFF_FFFF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int overlap_cnt = 0;
  logic [31:0] mem [64];
  logic [31:0] req_q [$];
  int          req_cyc [$];
  logic [31:0] got_instr [$];
  logic [31:0] got_pc [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    bit          deliver;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: one request at a time, response after lat cycles
  initial begin : mem_model
    logic [31:0] pend_addr;
    int          cd;
    bit          pending;
    pend_addr   = '0;
    cd          = 0;
    pending     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (pending) overlap_cnt++;
        req_q.push_back(imem_addr);
        req_cyc.push_back(cyc);
        pend_addr = imem_addr;
        cd        = lat;
        pending   = 1'b1;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pending) begin
        cd--;
        if (cd <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[pend_addr[7:2]];
          pending     = 1'b0;
        end
      end
    end
  end

  // Datapath side: log every accepted word
  initial begin : consumer
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        got_instr.push_back(instr_out);
        got_pc.push_back(pc_out);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  function automatic logic [31:0] wword(input logic [31:0] a);
    return 32'h0100_0000 | a;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q [$], input int k);
    if (k >= 0 && k < q.size()) return q[k];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_stream(input logic [31:0] sent_addr);
    for (int i = 0; i < 64; i++) mem[i] = wword(32'(i * 4));
    if (sent_addr != NO_SENT) mem[sent_addr[7:2]] = SENT;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(halted === 1'b1 && instr_valid === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: no halt/drain within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_got(input string name, input int k, input logic [31:0] ei, input logic [31:0] ep);
    chk({name, "_instr"}, qget(got_instr, k), ei);
    chk({name, "_pc"}, qget(got_pc, k), ep);
  endtask

  vec_t        prog [4];
  int          base_req, base_got, k, n, changes, vcount;
  bit          seen, late;
  logic [31:0] hold_i, hold_p;

  initial begin : main
    prog[0] = '{32'd0,  32'h0001_7820, 1'b1};
    prog[1] = '{32'd4,  32'h0022_8020, 1'b1};
    prog[2] = '{32'd8,  32'h0023_8822, 1'b1};
    prog[3] = '{32'd12, SENT,          1'b0};

    // Reset values
    fill_stream(NO_SENT);
    repeat (3) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic program with sentinel, 1-cycle memory, ready held high
    for (int i = 0; i < 4; i++) mem[prog[i].addr[7:2]] = prog[i].word;
    instr_ready = 1'b1;
    base_req = req_q.size();
    base_got = got_instr.size();
    pulse_start();
    n = 0;
    @(negedge clk);
    while (instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("first_valid_latency", 32'(cyc - ((req_cyc.size() > base_req) ? req_cyc[base_req] : 0)), 32'd2);
    wait_done("prog_halt", 200);
    chk("req_interval", 32'(((req_cyc.size() > base_req + 1) ? req_cyc[base_req + 1] : 0) -
                            ((req_cyc.size() > base_req) ? req_cyc[base_req] : 0)), 32'd2);
    chk("prog_delivered", 32'(got_instr.size() - base_got), 32'd3);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (prog[i].deliver) begin
        chk_got("prog_word", base_got + k, prog[i].word, prog[i].addr);
        k++;
      end
    end
    chk("prog_reqs", 32'(req_q.size() - base_req), 32'd4);
    chk("prog_last_addr", qget(req_q, req_q.size() - 1), 32'd12);
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_busy", 32'(busy), 32'd0);

    // Backpressure: buffer fills, fetch parks
    fill_stream(32'd80);
    instr_ready = 1'b0;
    base_req = req_q.size();
    base_got = got_instr.size();
    pulse_start();
    seen = 1'b0;
    changes = 0;
    repeat (30) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; hold_i = instr_out; hold_p = pc_out;
        end else if (instr_out !== hold_i || pc_out !== hold_p) begin
          changes++;
        end
      end
    end
    chk("bp_reqs", 32'(req_q.size() - base_req), 32'd4);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_instr", instr_out, wword(32'd0));
    chk("bp_pc", pc_out, 32'd0);
    chk("bp_stable_changes", 32'(changes), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_halted", 32'(halted), 32'd0);
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    repeat (15) @(negedge clk);
    chk("bp_one_more_req", 32'(req_q.size() - base_req), 32'd5);
    chk("bp_new_addr", qget(req_q, req_q.size() - 1), 32'd16);
    chk("bp_one_pop", 32'(got_instr.size() - base_got), 32'd1);
    chk_got("bp_popped", base_got, wword(32'd0), 32'd0);
    chk("bp_next_head", pc_out, 32'd4);

    // Ready toggling every cycle until the sentinel at 80
    base_got = got_instr.size();
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1 instr_ready = ~instr_ready;
      @(negedge clk);
      if (halted === 1'b1 && instr_valid === 1'b0) break;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL toggle_drain: no halt/drain within 400 cycles");
    end
    instr_ready = 1'b1;
    chk("toggle_count", 32'(got_instr.size() - base_got), 32'd19);
    for (int i = 0; i < 19; i++) chk_got("toggle_word", base_got + i, wword(32'(4 + 4 * i)), 32'(4 + 4 * i));
    chk("toggle_total_reqs", 32'(req_q.size() - base_req), 32'd21);

    // Slow memory; start during FETCH must be ignored
    lat = 5;
    fill_stream(32'd20);
    instr_ready = 1'b1;
    base_req = req_q.size();
    base_got = got_instr.size();
    overlap_cnt = 0;
    pulse_start();
    n = 0;
    while (req_q.size() < base_req + 2 && n < 50) begin @(negedge clk); n++; end
    pulse_start();
    wait_done("slow_halt", 500);
    chk("slow_overlap", 32'(overlap_cnt), 32'd0);
    chk("slow_reqs", 32'(req_q.size() - base_req), 32'd6);
    chk("slow_count", 32'(got_instr.size() - base_got), 32'd5);
    for (int i = 0; i < 5; i++) chk_got("slow_word", base_got + i, wword(32'(4 * i)), 32'(4 * i));
    chk("slow_hold_pc", pc_out, 32'd16);
    chk("slow_hold_instr", instr_out, wword(32'd16));

    // Reset with two words buffered and one request in flight
    lat = 3;
    fill_stream(32'd12);
    instr_ready = 1'b0;
    base_req = req_q.size();
    base_got = got_instr.size();
    pulse_start();
    n = 0;
    while (req_q.size() < base_req + 3 && n < 60) begin @(negedge clk); n++; end
    chk("mid_pre_valid", 32'(instr_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    late = 1'b0;
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_rvalid === 1'b1) late = 1'b1;
      if (instr_valid !== 1'b0) vcount++;
    end
    chk("mid_late_rvalid_seen", 32'(late), 32'd1);
    chk("mid_no_push", 32'(vcount), 32'd0);
    chk("mid_idle_reqs", 32'(req_q.size() - base_req), 32'd3);
    instr_ready = 1'b1;
    pulse_start();
    wait_done("mid_restart", 300);
    chk("mid_first_addr", qget(req_q, base_req + 3), 32'd0);
    chk("mid_count", 32'(got_instr.size() - base_got), 32'd3);
    for (int i = 0; i < 3; i++) chk_got("mid_word", base_got + i, wword(32'(4 * i)), 32'(4 * i));

    // Restart from HALT flushes buffered words
    lat = 1;
    fill_stream(32'd8);
    instr_ready = 1'b0;
    pulse_start();
    n = 0;
    while (halted !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("flush_pre_valid", 32'(instr_valid), 32'd1);
    chk("flush_pre_instr", instr_out, wword(32'd0));
    base_req = req_q.size();
    base_got = got_instr.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    wait_done("flush_refetch", 200);
    chk("flush_first_addr", qget(req_q, base_req), 32'd0);
    chk("flush_count", 32'(got_instr.size() - base_got), 32'd2);
    chk_got("flush_word0", base_got, wword(32'd0), 32'd0);
    chk_got("flush_word1", base_got + 1, wword(32'd4), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
